// File: rtl/coord_entry_pkg.sv
// Shared types for coordinate entry: FSM states, PS/2 set-2 scan constants, key classes.
// Pure declarations; no latency or backpressure of its own.
// decode_key maps a make code to its class and 4-bit value (letter 0-9, digit 1-10).
package coord_entry_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LET  = 2'd1,
        NUM  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [2:0] {
        KC_LETTER = 3'd0,
        KC_DIGIT  = 3'd1,
        KC_ENTER  = 3'd2,
        KC_BKSP   = 3'd3,
        KC_ESC    = 3'd4,
        KC_OTHER  = 3'd5
    } key_class_t;

    typedef struct packed {
        key_class_t cls;
        logic [3:0] val;
    } key_dec_t;

    function automatic key_dec_t decode_key(input logic [7:0] code);
        key_dec_t d;
        d.cls = KC_OTHER;
        d.val = 4'd0;
        case (code)
            8'h1C: begin d.cls = KC_LETTER; d.val = 4'd0;  end
            8'h32: begin d.cls = KC_LETTER; d.val = 4'd1;  end
            8'h21: begin d.cls = KC_LETTER; d.val = 4'd2;  end
            8'h23: begin d.cls = KC_LETTER; d.val = 4'd3;  end
            8'h24: begin d.cls = KC_LETTER; d.val = 4'd4;  end
            8'h2B: begin d.cls = KC_LETTER; d.val = 4'd5;  end
            8'h34: begin d.cls = KC_LETTER; d.val = 4'd6;  end
            8'h33: begin d.cls = KC_LETTER; d.val = 4'd7;  end
            8'h43: begin d.cls = KC_LETTER; d.val = 4'd8;  end
            8'h3B: begin d.cls = KC_LETTER; d.val = 4'd9;  end
            8'h16: begin d.cls = KC_DIGIT;  d.val = 4'd1;  end
            8'h1E: begin d.cls = KC_DIGIT;  d.val = 4'd2;  end
            8'h26: begin d.cls = KC_DIGIT;  d.val = 4'd3;  end
            8'h25: begin d.cls = KC_DIGIT;  d.val = 4'd4;  end
            8'h2E: begin d.cls = KC_DIGIT;  d.val = 4'd5;  end
            8'h36: begin d.cls = KC_DIGIT;  d.val = 4'd6;  end
            8'h3D: begin d.cls = KC_DIGIT;  d.val = 4'd7;  end
            8'h3E: begin d.cls = KC_DIGIT;  d.val = 4'd8;  end
            8'h46: begin d.cls = KC_DIGIT;  d.val = 4'd9;  end
            8'h45: begin d.cls = KC_DIGIT;  d.val = 4'd10; end
            SC_ENTER: d.cls = KC_ENTER;
            SC_BKSP:  d.cls = KC_BKSP;
            SC_ESC:   d.cls = KC_ESC;
            default:  d.cls = KC_OTHER;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/coord_entry_ctrl_ps2_prefix_filter.sv
// Strips F0/E0 prefixes from the PS/2 byte stream; optional typematic filter (COORD_REPEAT_FILTER_EN).
// makeStrobe is combinational from keyPressed and registered flags: zero added latency.
// No backpressure: every strobed byte is consumed in its own cycle.
module ps2_prefix_filter
    import coord_entry_pkg::*;
(
    input  logic       clock27,
    input  logic       reset_n,
    input  logic       keyPressed,
    input  logic [7:0] keyDataOut,
    output logic       makeStrobe,
    output logic [7:0] makeCode
);

    logic breakPending;
    logic extPending;
    logic is_prefix;
    logic make_raw;

    assign is_prefix = (keyDataOut == SC_BREAK) || (keyDataOut == SC_EXT);
    assign make_raw  = keyPressed && !is_prefix && !breakPending;
    assign makeCode  = keyDataOut;

    // E0 survives an F0 so that E0 F0 xx is still tracked as an extended break.
    always_ff @(posedge clock27 or negedge reset_n) begin
        if (!reset_n) begin
            breakPending <= 1'b0;
            extPending   <= 1'b0;
        end else if (keyPressed) begin
            breakPending <= (keyDataOut == SC_BREAK);
            extPending   <= (keyDataOut == SC_EXT) || ((keyDataOut == SC_BREAK) && extPending);
        end
    end

`ifdef COORD_REPEAT_FILTER_EN
    logic [7:0] last_code;
    logic       last_vld;
    logic       is_repeat;

    assign is_repeat  = last_vld && (last_code == keyDataOut);
    assign makeStrobe = make_raw && !is_repeat;

    always_ff @(posedge clock27 or negedge reset_n) begin
        if (!reset_n) begin
            last_code <= 8'h00;
            last_vld  <= 1'b0;
        end else if (keyPressed && !is_prefix) begin
            if (breakPending) begin
                if (last_vld && (last_code == keyDataOut))
                    last_vld <= 1'b0;
            end else begin
                last_code <= keyDataOut;
                last_vld  <= 1'b1;
            end
        end
    end
`else
    assign makeStrobe = make_raw;
`endif

endmodule

// File: rtl/coord_entry_ctrl.sv
// Keyboard coordinate entry (letter A-J, number 1-10, Enter) handed to the game core.
// One-cycle latency from keyPressed to all (registered) outputs; COORD_REPEAT_FILTER_EN drops typematic repeats.
// coordValid holds the committed coordinate until coordReady is seen; keys are ignored meanwhile.
module coord_entry_ctrl
    import coord_entry_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 270000000,
    parameter int TMO_W          = 29
) (
    input  logic       clock27,
    input  logic       reset_n,
    input  logic       keyPressed,
    input  logic [7:0] keyDataOut,
    input  logic       coordReady,
    output logic       coordValid,
    output logic [3:0] letter,
    output logic [3:0] number,
    output logic       keyError,
    output logic [9:0] led_r,
    output logic [7:0] led_g
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic             makeStrobe;
    logic [7:0]       makeCode;
    key_dec_t         dec;
    state_t           state, nxt_state;
    logic [3:0]       nxt_letter, nxt_number;
    logic             nxt_err;
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_entry;
    logic             tmo_hit;

    ps2_prefix_filter u_prefix (
        .clock27    (clock27),
        .reset_n    (reset_n),
        .keyPressed (keyPressed),
        .keyDataOut (keyDataOut),
        .makeStrobe (makeStrobe),
        .makeCode   (makeCode)
    );

    assign dec      = decode_key(makeCode);
    assign in_entry = (state == LET) || (state == NUM);
    // Any strobe, even a prefix byte, beats an expiring timeout in the same cycle.
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && in_entry && !keyPressed && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clock27 or negedge reset_n) begin
        if (!reset_n)
            tmo_cnt <= '0;
        else if (keyPressed || !in_entry)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_comb begin
        nxt_state  = state;
        nxt_letter = letter;
        nxt_number = number;
        nxt_err    = 1'b0;
        case (state)
            IDLE: if (makeStrobe) begin
                case (dec.cls)
                    KC_LETTER: begin nxt_letter = dec.val; nxt_state = LET; end
                    KC_BKSP, KC_ESC: ;
                    default: nxt_err = 1'b1;
                endcase
            end
            LET: if (makeStrobe) begin
                case (dec.cls)
                    KC_LETTER: nxt_letter = dec.val;
                    KC_DIGIT:  begin nxt_number = dec.val; nxt_state = NUM; end
                    KC_BKSP, KC_ESC: begin nxt_letter = 4'd0; nxt_state = IDLE; end
                    default:   nxt_err = 1'b1;
                endcase
            end
            NUM: if (makeStrobe) begin
                case (dec.cls)
                    KC_DIGIT:  nxt_number = dec.val;
                    KC_LETTER: begin nxt_letter = dec.val; nxt_number = 4'd0; nxt_state = LET; end
                    KC_ENTER:  nxt_state = HOLD;
                    KC_BKSP:   begin nxt_number = 4'd0; nxt_state = LET; end
                    KC_ESC:    begin nxt_letter = 4'd0; nxt_number = 4'd0; nxt_state = IDLE; end
                    default:   nxt_err = 1'b1;
                endcase
            end
            HOLD: if (coordReady) begin
                nxt_letter = 4'd0;
                nxt_number = 4'd0;
                nxt_state  = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
        if (tmo_hit) begin
            nxt_letter = 4'd0;
            nxt_number = 4'd0;
            nxt_state  = IDLE;
        end
    end

    // LEDs are derived from next-state values so they line up with letter/number.
    always_ff @(posedge clock27 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            letter     <= 4'd0;
            number     <= 4'd0;
            keyError   <= 1'b0;
            coordValid <= 1'b0;
            led_r      <= 10'd0;
            led_g      <= 8'b0001_0000;
        end else begin
            state      <= nxt_state;
            letter     <= nxt_letter;
            number     <= nxt_number;
            keyError   <= nxt_err;
            coordValid <= (nxt_state == HOLD);
            led_r      <= (nxt_state == IDLE) ? 10'd0 : (10'd1 << nxt_letter);
            led_g      <= {4'b0001 << nxt_state, nxt_number};
        end
    end

endmodule

// File: tb/tb_coord_entry_ctrl.sv
// Directed bench for coord_entry_ctrl with the timeout shortened to 20 cycles.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each key.
module tb_coord_entry_ctrl;

    localparam logic [3:0] S_I = 4'b0001;
    localparam logic [3:0] S_L = 4'b0010;
    localparam logic [3:0] S_N = 4'b0100;
    localparam logic [3:0] S_H = 4'b1000;

    logic       clock27    = 1'b0;
    logic       reset_n    = 1'b0;
    logic       keyPressed = 1'b0;
    logic [7:0] keyDataOut = 8'h00;
    logic       coordReady = 1'b0;
    logic       coordValid;
    logic [3:0] letter;
    logic [3:0] number;
    logic       keyError;
    logic [9:0] led_r;
    logic [7:0] led_g;

    int n_vec = 0;
    int n_err = 0;

    coord_entry_ctrl #(
        .TIMEOUT_CYCLES (20),
        .TMO_W          (5)
    ) dut (
        .clock27    (clock27),
        .reset_n    (reset_n),
        .keyPressed (keyPressed),
        .keyDataOut (keyDataOut),
        .coordReady (coordReady),
        .coordValid (coordValid),
        .letter     (letter),
        .number     (number),
        .keyError   (keyError),
        .led_r      (led_r),
        .led_g      (led_g)
    );

    always #5 clock27 = ~clock27;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full visible state: handshake, coordinate, both LED banks.
    task automatic chk_out(input string tag, input logic vld, input logic [3:0] ltr,
                           input logic [3:0] num, input logic [3:0] st);
        logic [9:0] exp_r;
        exp_r = (st == S_I) ? 10'd0 : (10'd1 << ltr);
        chk({tag, "/vld"},   32'(coordValid), 32'(vld));
        chk({tag, "/let"},   32'(letter),     32'(ltr));
        chk({tag, "/num"},   32'(number),     32'(num));
        chk({tag, "/led_r"}, 32'(led_r),      32'(exp_r));
        chk({tag, "/led_g"}, 32'(led_g),      32'({st, num}));
    endtask

    task automatic key(input logic [7:0] b);
        @(negedge clock27);
        keyPressed = 1'b1;
        keyDataOut = b;
        @(negedge clock27);
        keyPressed = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock27);
    endtask

    task automatic accept(input string tag);
        @(negedge clock27);
        coordReady = 1'b1;
        @(negedge clock27);
        coordReady = 1'b0;
        chk_out(tag, 1'b0, 4'd0, 4'd0, S_I);
    endtask

    initial begin
        idle(2);
        chk_out("rst", 1'b0, 4'd0, 4'd0, S_I);
        chk("rst/err", 32'(keyError), 32'd0);
        reset_n = 1'b1;

        // A3 committed, held across an extra cycle and a stray key, then accepted.
        key(8'h1C); chk_out("a3_let", 1'b0, 4'd0, 4'd0, S_L);
        key(8'h26); chk_out("a3_num", 1'b0, 4'd0, 4'd3, S_N);
        key(8'h5A); chk_out("a3_ent", 1'b1, 4'd0, 4'd3, S_H);
        idle(1);    chk_out("a3_held", 1'b1, 4'd0, 4'd3, S_H);
        key(8'h32); chk_out("a3_hold_key", 1'b1, 4'd0, 4'd3, S_H);
        chk("a3_hold_err", 32'(keyError), 32'd0);
        accept("a3_acc");

        // B10 with break sequences that must not re-apply the key.
        key(8'h32); key(8'hF0); key(8'h32);
        chk_out("b10_brk", 1'b0, 4'd1, 4'd0, S_L);
        key(8'h45); key(8'hF0); key(8'h45);
        chk_out("b10_num", 1'b0, 4'd1, 4'd10, S_N);
        key(8'hF0); key(8'h5A);
        chk_out("b10_brk_ent", 1'b0, 4'd1, 4'd10, S_N);
        key(8'h5A); chk_out("b10_ent", 1'b1, 4'd1, 4'd10, S_H);
        accept("b10_acc");

        // Backspace from NUM drops the number only.
        key(8'h21); key(8'h16); key(8'h66);
        chk_out("c2_bksp", 1'b0, 4'd2, 4'd0, S_L);
        key(8'h1E); key(8'h5A);
        chk_out("c2_ent", 1'b1, 4'd2, 4'd2, S_H);
        accept("c2_acc");

        // Rejected keys pulse keyError for exactly one cycle.
        key(8'h16); chk("err_idle", 32'(keyError), 32'd1);
        chk_out("err_idle_st", 1'b0, 4'd0, 4'd0, S_I);
        idle(1);    chk("err_idle_end", 32'(keyError), 32'd0);
        key(8'h24); key(8'h5A);
        chk("err_let", 32'(keyError), 32'd1);
        chk_out("err_let_st", 1'b0, 4'd4, 4'd0, S_L);
        idle(1);    chk("err_let_end", 32'(keyError), 32'd0);
        key(8'h76); chk_out("esc", 1'b0, 4'd0, 4'd0, S_I);

        // Extended Enter (E0 5A) commits too.
        key(8'h1C); key(8'h16); key(8'hE0); key(8'h5A);
        chk_out("ext_ent", 1'b1, 4'd0, 4'd1, S_H);
        chk("ext_ent_err", 32'(keyError), 32'd0);
        accept("ext_acc");

        // Timeout after 20 quiet cycles in LET.
        key(8'h24);
        idle(19); chk_out("tmo_19", 1'b0, 4'd4, 4'd0, S_L);
        idle(1);  chk_out("tmo_20", 1'b0, 4'd0, 4'd0, S_I);

        // A key on the last cycle wins and restarts the count.
        key(8'h24);
        idle(18);
        key(8'h1C); chk_out("tmo_save", 1'b0, 4'd0, 4'd0, S_L);
        idle(19);   chk_out("tmo_save_19", 1'b0, 4'd0, 4'd0, S_L);
        idle(1);    chk_out("tmo_save_20", 1'b0, 4'd0, 4'd0, S_I);

        // Auto-repeat of a rejected key; the break re-arms it in both builds.
        key(8'h16); chk("rep_err1", 32'(keyError), 32'd1);
        key(8'h16);
`ifdef COORD_REPEAT_FILTER_EN
        chk("rep_err2", 32'(keyError), 32'd0);
`else
        chk("rep_err2", 32'(keyError), 32'd1);
`endif
        key(8'hF0); key(8'h16);
        key(8'h16); chk("rep_err3", 32'(keyError), 32'd1);
        for (int i = 0; i < 3; i++) begin
            key(8'h1C);
            chk($sformatf("rep_let%0d_err", i), 32'(keyError), 32'd0);
            chk_out($sformatf("rep_let%0d", i), 1'b0, 4'd0, 4'd0, S_L);
        end
        key(8'h76);

        // coordReady outside HOLD is ignored.
        coordReady = 1'b1;
        key(8'h43); chk_out("rdy_let", 1'b0, 4'd8, 4'd0, S_L);
        key(8'h3E); chk_out("rdy_num", 1'b0, 4'd8, 4'd8, S_N);
        coordReady = 1'b0;
        key(8'h5A); chk_out("rdy_hold", 1'b1, 4'd8, 4'd8, S_H);

        // Asynchronous reset drops coordValid without waiting for a clock edge.
        @(negedge clock27);
        #2 reset_n = 1'b0;
        #1 chk("arst_vld", 32'(coordValid), 32'd0);
        chk("arst_led_g", 32'(led_g), 32'h10);
        @(negedge clock27);
        reset_n = 1'b1;
        idle(1);
        chk_out("arst_after", 1'b0, 4'd0, 4'd0, S_I);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
